tx_serializer: RTL and testbench
================================

Name: tx_serializer

Overview:
- Transmit stage directly downstream of the memory-access controller (RW_flow).
- When the controller raises TxData, this block captures the word read from memory and shifts it out as an asynchronous-style serial frame: start bit, data LSB first, stop bit.
- On completion it returns the one-cycle TxDone pulse that the controller waits on before leaving its transmit state.

Parameters:
- DATA_WIDTH, 8: width of the word captured and serialized.
- BIT_CYCLES, 4: Clk cycles per serial bit. Legal range is 2..255.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Active  input  1  chip active; a new frame starts only when high.
- TxData  input  1  transmit request from controller; level, held until TxDone is seen.
- DataIn  input  DATA_WIDTH  memory read data; valid in the cycle TxData is first sampled high.
- SerOut  output  1  serial line; idles high.
- TxBusy  output  1  high from frame start through the TxDone cycle.
- TxDone  output  1  one-cycle completion pulse to controller.

Behaviour:
- Reset (sampled on rising Clk while Reset=1):
  - State goes to IDLE; SerOut=1, TxBusy=0, TxDone=0.
  - Shift register and bit/cycle counters clear; armed flag is set to 1.
  - Reset overrides everything, including mid-frame: the line returns high on the next edge and the partial frame is abandoned with no TxDone.
- States: IDLE, START, DATA, STOP, DONE (encoding in shared package).
- IDLE:
  - If TxData=1, Active=1 and armed=1 at an edge: latch DataIn into the shift register, clear armed, go to START.
  - Otherwise stay in IDLE. TxData is ignored while Active=0.
- START: SerOut=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - SerOut = shift_reg[0] for BIT_CYCLES cycles per bit.
  - Shift right at the end of each bit period.
  - After DATA_WIDTH bits, go to STOP.
- STOP: SerOut=1 for BIT_CYCLES cycles, then go to DONE.
- DONE: TxDone=1 for exactly one cycle, SerOut=1, then unconditionally go to IDLE.
- Latency and framing:
  - First edge sampling TxData=1 is edge k; SerOut falls after edge k.
  - The frame occupies (DATA_WIDTH+2)*BIT_CYCLES cycles.
  - TxDone is high in the following cycle; TxBusy falls with it.
- Re-arm:
  - armed is set again only when TxData is sampled 0 in any state.
  - A TxData level held past TxDone therefore never retriggers a second frame.
- Mid-frame changes:
  - TxData, DataIn and Active changing mid-frame have no effect; the frame always completes once started.
- Counters:
  - Cycle counter is $clog2(BIT_CYCLES) bits and reloads to 0 at each bit boundary.
  - Bit index is $clog2(DATA_WIDTH)+1 bits; wrap-around is not permitted.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package tx_pkg holds:
  - the state typedef/localparams (IDLE=0 … DONE=4, 3 bits);
  - frame constants START_BIT=0 and STOP_BIT=1.
- One sub-module, bit_timer:
  - a parameterised BIT_CYCLES down-counter with a clear input;
  - produces a one-cycle bit_tick at the end of each bit period.

Test Plan:
- Reset held 2 cycles, then released with TxData=0 → SerOut=1, TxBusy=0, TxDone=0 throughout; the same values hold during reset.
- Active=1, DataIn=8'hA5, TxData raised at edge k and held until TxDone (BIT_CYCLES=4):
  - SerOut sequence per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1;
  - TxDone is high only in cycle k+41; TxBusy is high for cycles k+1..k+41.
- TxData still held high for 10 cycles after TxDone → no second frame; SerOut stays 1.
- TxData then dropped for 1 cycle and raised with DataIn=8'h00 → new frame with 8 zero data bits and a correct stop bit.
- Active=0 with TxData=1 → no frame. Active later raised to 1 while TxData is still high → frame starts on the next edge.
- Reset asserted during data bit 3 of an 8'hFF frame → SerOut=1 and TxBusy=0 after that edge, with no TxDone. A fresh request after reset sends a complete frame.

Source files
------------

// File: rtl/tx_serializer_pkg.sv
// Shared state encoding and frame-bit constants for the transmit serializer.
// Pure declarations: no timing and no flow control of its own.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_serializer_if.sv
// Controller-to-serializer bundle: request level, read data, chip enable, serial line and status.
// The controller holds TxData as a level until it observes the one-cycle TxDone pulse.
interface tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Active;
    logic                  TxData;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  SerOut;
    logic                  TxBusy;
    logic                  TxDone;

    modport master (
        output Active,
        output TxData,
        output DataIn,
        input  SerOut,
        input  TxBusy,
        input  TxDone
    );

    modport slave (
        input  Active,
        input  TxData,
        input  DataIn,
        output SerOut,
        output TxBusy,
        output TxDone
    );
endinterface

// File: rtl/tx_serializer_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES clocks and flags the last one with bit_tick_o.
// One tick every BIT_CYCLES cycles after clear; clr_i holds the count at zero.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_tick_o
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == LAST_CYCLE);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tx_serializer.sv
// Captures a memory word on a TxData request and sends it as start bit, data LSB first, stop bit.
// Frame is (DATA_WIDTH+2)*BIT_CYCLES cycles after the request edge, then a one-cycle TxDone; no input backpressure.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    tx_serializer_if.slave  bus
);
    localparam int BIW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [BIW-1:0]        bit_idx_q;
    logic                  armed_q;
    logic                  ser_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_tick;
    logic                  timer_clr;

    assign shift_d   = shift_q >> 1;
    assign timer_clr = (state_q == IDLE) || (state_q == DONE);

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clr_i      (timer_clr),
        .bit_tick_o (bit_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            armed_q   <= 1'b1;
            ser_q     <= STOP_BIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // A request level must drop once before it can start another frame.
            if (!bus.TxData) begin
                armed_q <= 1'b1;
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.TxData && bus.Active && armed_q) begin
                        shift_q   <= bus.DataIn;
                        armed_q   <= 1'b0;
                        bit_idx_q <= '0;
                        ser_q     <= START_BIT;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        ser_q   <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_d;
                        if (bit_idx_q == LAST_BIT) begin
                            ser_q   <= STOP_BIT;
                            state_q <= STOP;
                        end else begin
                            ser_q     <= shift_d[0];
                            bit_idx_q <= bit_idx_q + BIW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ser_q   <= STOP_BIT;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.SerOut = ser_q;
    assign bus.TxBusy = busy_q;
    assign bus.TxDone = done_q;
endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer with DATA_WIDTH=8, BIT_CYCLES=4 (40-cycle frames).
module tb_tx_serializer;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    tx_serializer_if #(.DATA_WIDTH(8)) bus ();

    tx_serializer #(
        .DATA_WIDTH (8),
        .BIT_CYCLES (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected line level in cycle c after the request edge (c=1 is the first start-bit cycle).
    function automatic logic exp_ser(input logic [7:0] d, input int c);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        if (c < 1 || c > 40) return 1'b1;
        return f[(c - 1) / 4];
    endfunction

    task automatic test_reset();
        bus.Active = 1'b0;
        bus.TxData = 1'b0;
        bus.DataIn = 8'h00;
        Reset      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            if (i == 1) Reset = 1'b0;
            checks++;
            if (bus.SerOut !== 1'b1 || bus.TxBusy !== 1'b0 || bus.TxDone !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d got ser/busy/done=%b%b%b exp=100",
                         i, bus.SerOut, bus.TxBusy, bus.TxDone);
            end
        end
        @(posedge Clk);
    endtask

    task automatic test_frame_a5();
        #1;
        bus.Active = 1'b1;
        bus.DataIn = 8'hA5;
        bus.TxData = 1'b1;
        @(posedge Clk);
        for (int c = 1; c <= 42; c++) begin
            #1;
            checks++;
            if (bus.SerOut !== exp_ser(8'hA5, c) || bus.TxBusy !== (c <= 41) ||
                bus.TxDone !== (c == 41)) begin
                errors++;
                $display("FAIL frame_a5 c=%0d got ser/busy/done=%b%b%b exp=%b%b%b", c,
                         bus.SerOut, bus.TxBusy, bus.TxDone, exp_ser(8'hA5, c), c <= 41, c == 41);
            end
            @(posedge Clk);
        end
    endtask

    task automatic test_hold_no_retrigger();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.SerOut !== 1'b1 || bus.TxBusy !== 1'b0 || bus.TxDone !== 1'b0) begin
                errors++;
                $display("FAIL hold i=%0d got ser/busy/done=%b%b%b exp=100",
                         i, bus.SerOut, bus.TxBusy, bus.TxDone);
            end
            @(posedge Clk);
        end
    endtask

    task automatic test_rearm_zero();
        #1;
        bus.TxData = 1'b0;
        @(posedge Clk);
        #1;
        bus.TxData = 1'b1;
        bus.DataIn = 8'h00;
        @(posedge Clk);
        for (int c = 1; c <= 42; c++) begin
            #1;
            // Mid-frame input changes must not disturb the frame in flight.
            if (c == 10) begin
                bus.DataIn = 8'hFF;
                bus.Active = 1'b0;
            end
            checks++;
            if (bus.SerOut !== exp_ser(8'h00, c) || bus.TxBusy !== (c <= 41) ||
                bus.TxDone !== (c == 41)) begin
                errors++;
                $display("FAIL rearm_00 c=%0d got ser/busy/done=%b%b%b exp=%b%b%b", c,
                         bus.SerOut, bus.TxBusy, bus.TxDone, exp_ser(8'h00, c), c <= 41, c == 41);
            end
            @(posedge Clk);
        end
    endtask

    task automatic test_active_gate();
        #1;
        bus.TxData = 1'b0;
        @(posedge Clk);
        #1;
        bus.TxData = 1'b1;
        bus.DataIn = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (bus.SerOut !== 1'b1 || bus.TxBusy !== 1'b0) begin
                errors++;
                $display("FAIL inactive i=%0d got ser/busy=%b%b exp=10", i, bus.SerOut, bus.TxBusy);
            end
        end
        bus.Active = 1'b1;
        @(posedge Clk);
        for (int c = 1; c <= 42; c++) begin
            #1;
            checks++;
            if (bus.SerOut !== exp_ser(8'h3C, c) || bus.TxBusy !== (c <= 41) ||
                bus.TxDone !== (c == 41)) begin
                errors++;
                $display("FAIL active_3c c=%0d got ser/busy/done=%b%b%b exp=%b%b%b", c,
                         bus.SerOut, bus.TxBusy, bus.TxDone, exp_ser(8'h3C, c), c <= 41, c == 41);
            end
            @(posedge Clk);
        end
    endtask

    task automatic test_reset_midframe();
        #1;
        bus.TxData = 1'b0;
        @(posedge Clk);
        #1;
        bus.TxData = 1'b1;
        bus.DataIn = 8'hFF;
        @(posedge Clk);
        for (int c = 1; c <= 17; c++) begin
            #1;
            checks++;
            if (bus.SerOut !== exp_ser(8'hFF, c) || bus.TxBusy !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_ff c=%0d got ser/busy=%b%b exp=%b1",
                         c, bus.SerOut, bus.TxBusy, exp_ser(8'hFF, c));
            end
            @(posedge Clk);
        end
        // Now in the second cycle of data bit 3.
        #1;
        Reset      = 1'b1;
        bus.TxData = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 45; i++) begin
            checks++;
            if (bus.SerOut !== 1'b1 || bus.TxBusy !== 1'b0 || bus.TxDone !== 1'b0) begin
                errors++;
                $display("FAIL post_reset i=%0d got ser/busy/done=%b%b%b exp=100",
                         i, bus.SerOut, bus.TxBusy, bus.TxDone);
            end
            @(posedge Clk);
            #1;
        end
        bus.TxData = 1'b1;
        bus.DataIn = 8'h81;
        @(posedge Clk);
        for (int c = 1; c <= 42; c++) begin
            #1;
            checks++;
            if (bus.SerOut !== exp_ser(8'h81, c) || bus.TxBusy !== (c <= 41) ||
                bus.TxDone !== (c == 41)) begin
                errors++;
                $display("FAIL fresh_81 c=%0d got ser/busy/done=%b%b%b exp=%b%b%b", c,
                         bus.SerOut, bus.TxBusy, bus.TxDone, exp_ser(8'h81, c), c <= 41, c == 41);
            end
            @(posedge Clk);
        end
        #1;
        bus.TxData = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_frame_a5();
        test_hold_no_retrigger();
        test_rearm_zero();
        test_active_gate();
        test_reset_midframe();
        repeat (2) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
